// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: alignment check, bus request shaping, req/addr_ok/data_ok
// handshake and raw read-data return with byte-lane select for load extraction.
module dmem_req_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_in_valid,
    input  logic [6:0]  i_lsu_op,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_st_data,
    input  logic        i_out_ready,
    output logic        o_data_req,
    output logic        o_data_wr,
    output logic [63:0] o_data_addr,
    output logic [7:0]  o_data_wstrb,
    output logic [63:0] o_data_wdata,
    input  logic        i_data_addr_ok,
    input  logic        i_data_data_ok,
    input  logic [63:0] i_data_rdata,
    output logic        o_out_valid,
    output logic [63:0] o_out_rdata,
    output logic [7:0]  o_out_sel,
    output logic        o_misalign,
    output logic        o_stall_req
);

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_drop;
    logic [AW-1:0]   r_addr;
    logic            r_wr;
    logic [SW-1:0]   r_wstrb;
    logic [DW-1:0]   r_wdata;
    logic [SW-1:0]   r_sel;
    logic [DW-1:0]   r_rdata;

    logic            w_en;
    logic            w_we;
    logic [3:0]      w_size;
    logic [2:0]      w_off;
    logic [SW-1:0]   w_sel;
    logic [DW-1:0]   w_wdata;
    logic            w_misaligned;
    logic            w_idle_op;
    logic            w_accept;
    logic            w_drop;
    logic            w_capture;
    logic            w_unused_uns;

    assign w_en         = i_lsu_op[6];
    assign w_we         = i_lsu_op[5];
    assign w_size       = i_lsu_op[4:1];
    assign w_off        = i_addr[2:0];
    // Signedness is consumed by the downstream extraction stage, not here.
    assign w_unused_uns = i_lsu_op[0];

    // Lane select, replicated store data and alignment for the presented op.
    always_comb begin : lane_decode
        w_sel        = 8'h01 << w_off;
        w_wdata      = {8{i_st_data[7:0]}};
        w_misaligned = 1'b0;
        if (w_size[3]) begin
            w_sel        = 8'hFF;
            w_wdata      = i_st_data;
            w_misaligned = (w_off != 3'd0);
        end else if (w_size[2]) begin
            w_sel        = 8'h0F << w_off;
            w_wdata      = {2{i_st_data[31:0]}};
            w_misaligned = (w_off[1:0] != 2'd0);
        end else if (w_size[1]) begin
            w_sel        = 8'h03 << w_off;
            w_wdata      = {4{i_st_data[15:0]}};
            w_misaligned = w_off[0];
        end
    end

    assign w_idle_op = (r_state == S_IDLE) & i_in_valid & w_en & ~i_flush;
    assign w_accept  = w_idle_op & ~w_misaligned;
    assign w_drop    = r_drop | i_flush;
    assign w_capture = i_data_data_ok &
                       (((r_state == S_REQ) & i_data_addr_ok) | (r_state == S_WAIT));

    always_ff @(posedge clk) begin : fsm_state
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_REQ;
            S_REQ: begin
                if (i_data_addr_ok) begin
                    if (i_data_data_ok) w_state_nxt = w_drop ? S_IDLE : S_RESP;
                    else                w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (i_data_data_ok) w_state_nxt = w_drop ? S_IDLE : S_RESP;
            S_RESP: if (i_out_ready || i_flush) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin : fsm_out
        o_data_req  = 1'b0;
        o_out_valid = 1'b0;
        o_stall_req = 1'b0;
        o_misalign  = w_idle_op & w_misaligned;
        case (r_state)
            S_IDLE: o_stall_req = w_accept;
            S_REQ: begin
                o_data_req  = 1'b1;
                o_stall_req = 1'b1;
            end
            S_WAIT: o_stall_req = 1'b1;
            S_RESP: begin
                o_out_valid = 1'b1;
                o_stall_req = ~i_out_ready;
            end
            default: o_stall_req = 1'b0;
        endcase
    end

    // A flushed transaction still has to drain on the bus; remember to discard its response.
    always_ff @(posedge clk) begin : drop_reg
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (w_state_nxt == S_IDLE) begin
            r_drop <= 1'b0;
        end else if (i_flush && (r_state == S_REQ || r_state == S_WAIT)) begin
            r_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin : dp_regs
        if (!rst_n) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= {i_addr[AW-1:3], 3'b000};
                r_wr    <= w_we;
                r_wstrb <= w_we ? w_sel : SW'(0);
                r_wdata <= w_wdata;
                r_sel   <= w_sel;
            end
            if (w_capture) begin
                r_rdata <= r_wr ? DW'(0) : i_data_rdata;
            end
        end
    end

    assign o_data_wr    = r_wr;
    assign o_data_addr  = r_addr;
    assign o_data_wstrb = r_wstrb;
    assign o_data_wdata = r_wdata;
    assign o_out_rdata  = r_rdata;
    assign o_out_sel    = r_sel;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: directed scenarios plus randomized transactions
// checked every cycle against a transaction-level reference model.
module tb_dmem_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [6:0]  lsu_op;
    logic [63:0] addr;
    logic [63:0] st_data;
    logic        out_ready;
    logic        data_req;
    logic        data_wr;
    logic [63:0] data_addr;
    logic [7:0]  data_wstrb;
    logic [63:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [63:0] data_rdata;
    logic        out_valid;
    logic [63:0] out_rdata;
    logic [7:0]  out_sel;
    logic        misalign;
    logic        stall_req;

    int unsigned n_chk;
    int unsigned n_pass;
    logic [63:0] obs_addr, obs_wstrb, obs_wdata, obs_rdata, obs_sel;

    dmem_req_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_flush        (flush),
        .i_in_valid     (in_valid),
        .i_lsu_op       (lsu_op),
        .i_addr         (addr),
        .i_st_data      (st_data),
        .i_out_ready    (out_ready),
        .o_data_req     (data_req),
        .o_data_wr      (data_wr),
        .o_data_addr    (data_addr),
        .o_data_wstrb   (data_wstrb),
        .o_data_wdata   (data_wdata),
        .i_data_addr_ok (data_addr_ok),
        .i_data_data_ok (data_data_ok),
        .i_data_rdata   (data_rdata),
        .o_out_valid    (out_valid),
        .o_out_rdata    (out_rdata),
        .o_out_sel      (out_sel),
        .o_misalign     (misalign),
        .o_stall_req    (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: access of 2^szi bytes at byte address a.
    function automatic logic [7:0] m_sel(input int szi, input logic [63:0] a);
        int nb;
        int off;
        nb  = 1 << szi;
        off = int'(a[2:0]);
        if (nb == 8) return 8'hFF;
        return 8'(((1 << nb) - 1) << off);
    endfunction

    function automatic bit m_mis(input int szi, input logic [63:0] a);
        return (int'(a[2:0]) % (1 << szi)) != 0;
    endfunction

    function automatic logic [63:0] m_wdata(input int szi, input logic [63:0] d);
        logic [63:0] r;
        int nb;
        nb = 1 << szi;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[(i % nb)*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        flush        = 1'b0;
        lsu_op       = '0;
        out_ready    = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = {$urandom(), $urandom()};
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    data_req, 0);
        chk({tag, "_wr"},     data_wr, 0);
        chk({tag, "_addr"},   data_addr, 0);
        chk({tag, "_wstrb"},  data_wstrb, 0);
        chk({tag, "_wdata"},  data_wdata, 0);
        chk({tag, "_ov"},     out_valid, 0);
        chk({tag, "_rdata"},  out_rdata, 0);
        chk({tag, "_sel"},    out_sel, 0);
        chk({tag, "_mis"},    misalign, 0);
        chk({tag, "_stall"},  stall_req, 0);
    endtask

    // One op from EX through bus handshake to downstream hand-off, checked cycle by cycle.
    // fl_at: cycle index (from first REQ cycle) where flush is raised, -1 for none.
    task automatic do_txn(input bit en, input bit we, input int szi, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] rd, input int a_lat,
                          input int d_lat, input int r_lat, input int fl_at, input bit resp_flush);
        logic [7:0] sel;
        bit         mis;
        bit         dropped;
        bit         last;
        int         k;
        sel     = m_sel(szi, a);
        mis     = m_mis(szi, a);
        dropped = 1'b0;
        k       = 0;

        in_valid = 1'b1;
        lsu_op   = {en, we, 4'(1 << szi), 1'($urandom_range(0, 1))};
        addr     = a;
        st_data  = d;
        settle();
        chk("acc_misalign", misalign, 64'(en & mis));
        chk("acc_stall", stall_req, 64'(en & !mis));
        chk("acc_req", data_req, 0);
        tick();
        idle_inputs();
        if (!en || mis) begin
            settle();
            chk("rej_req", data_req, 0);
            chk("rej_stall", stall_req, 0);
            chk("rej_misalign", misalign, 0);
            tick();
            return;
        end

        for (int i = 0; i <= a_lat; i++) begin
            data_addr_ok = (i == a_lat);
            data_data_ok = (i == a_lat) ? (d_lat == 0) : 1'($urandom_range(0, 1));
            data_rdata   = (i == a_lat && d_lat == 0) ? rd : {$urandom(), $urandom()};
            flush        = (k == fl_at);
            if (flush) dropped = 1'b1;
            settle();
            chk("req_req", data_req, 1);
            chk("req_wr", data_wr, 64'(we));
            chk("req_addr", data_addr, a & ~64'h7);
            chk("req_wstrb", data_wstrb, we ? 64'(sel) : 64'd0);
            chk("req_wdata", data_wdata, m_wdata(szi, d));
            chk("req_stall", stall_req, 1);
            chk("req_ov", out_valid, 0);
            obs_addr  = data_addr;
            obs_wstrb = 64'(data_wstrb);
            obs_wdata = data_wdata;
            tick();
            k++;
        end
        idle_inputs();

        for (int j = 1; j <= d_lat; j++) begin
            data_data_ok = (j == d_lat);
            data_rdata   = (j == d_lat) ? rd : {$urandom(), $urandom()};
            flush        = (k == fl_at);
            if (flush) dropped = 1'b1;
            settle();
            chk("wait_req", data_req, 0);
            chk("wait_stall", stall_req, 1);
            chk("wait_ov", out_valid, 0);
            tick();
            k++;
        end
        idle_inputs();

        if (!dropped) begin
            for (int r = 0; r <= r_lat; r++) begin
                last      = (r == r_lat);
                out_ready = last & !resp_flush;
                flush     = last & resp_flush;
                settle();
                chk("resp_ov", out_valid, 1);
                chk("resp_rdata", out_rdata, we ? 64'd0 : rd);
                chk("resp_sel", out_sel, 64'(sel));
                chk("resp_stall", stall_req, 64'(!out_ready));
                chk("resp_req", data_req, 0);
                obs_rdata = out_rdata;
                obs_sel   = 64'(out_sel);
                tick();
            end
            idle_inputs();
        end

        settle();
        chk("idle_ov", out_valid, 0);
        chk("idle_req", data_req, 0);
        chk("idle_stall", stall_req, 0);
        tick();
    endtask

    bit          r_en, r_we, r_rf;
    int          r_szi, r_al, r_dl, r_rl, r_fl;
    logic [63:0] r_a, r_d, r_rd;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        addr   = '0;
        st_data = '0;
        idle_inputs();
        repeat (3) tick();
        settle();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // SB at 0x1003: one-cycle bus, result two cycles after accept.
        do_txn(1, 1, 0, 64'h1003, 64'hAB, 64'hDEAD_BEEF_0000_1111, 0, 0, 0, -1, 0);
        chk("sb_addr", obs_addr, 64'h1000);
        chk("sb_wstrb", obs_wstrb, 64'h08);
        chk("sb_wdata", obs_wdata, 64'hABAB_ABAB_ABAB_ABAB);
        chk("sb_rdata", obs_rdata, 64'h0);

        // LW at 0x2004.
        do_txn(1, 0, 2, 64'h2004, 64'h0, 64'h1122_3344_5566_7788, 0, 1, 0, -1, 0);
        chk("lw_sel", obs_sel, 64'hF0);
        chk("lw_rdata", obs_rdata, 64'h1122_3344_5566_7788);
        chk("lw_wstrb", obs_wstrb, 64'h0);

        // Misaligned LH.
        do_txn(1, 0, 1, 64'h3001, 64'h0, 64'h0, 0, 0, 0, -1, 0);

        // Slow bus and held response.
        do_txn(1, 0, 3, 64'h5000, 64'h0, 64'hCAFE_F00D_1234_5678, 3, 2, 2, -1, 0);

        // Flush in REQ, then flush in RESP.
        do_txn(1, 0, 2, 64'h6008, 64'h0, 64'h0123_4567_89AB_CDEF, 2, 1, 0, 0, 0);
        do_txn(1, 1, 1, 64'h7006, 64'h5A5A, 64'h0, 0, 0, 1, -1, 1);

        // Reset while waiting for data_ok.
        in_valid = 1'b1;
        lsu_op   = {1'b1, 1'b0, 4'b1000, 1'b0};
        addr     = 64'h4000;
        st_data  = 64'h0;
        tick();
        idle_inputs();
        data_addr_ok = 1'b1;
        settle();
        chk("rstw_req", data_req, 1);
        tick();
        idle_inputs();
        settle();
        chk("rstw_stall", stall_req, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk_all_zero("rstw");
        tick();
        do_txn(1, 1, 3, 64'h0, 64'h0, 64'h0, 0, 0, 0, -1, 0);

        for (int t = 0; t < 80; t++) begin
            r_en  = ($urandom_range(0, 9) != 0);
            r_we  = 1'($urandom_range(0, 1));
            r_szi = int'($urandom_range(0, 3));
            r_a   = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0) r_a[2:0] = 3'd0;
            r_d   = {$urandom(), $urandom()};
            r_rd  = {$urandom(), $urandom()};
            r_al  = int'($urandom_range(0, 3));
            r_dl  = int'($urandom_range(0, 3));
            r_rl  = int'($urandom_range(0, 2));
            r_fl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, r_al + r_dl)) : -1;
            r_rf  = ($urandom_range(0, 7) == 0);
            do_txn(r_en, r_we, r_szi, r_a, r_d, r_rd, r_al, r_dl, r_rl, r_fl, r_rf);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
